dispense_status_tx: RTL and testbench

Reports each completed dispense job to the host over a UART 8N1 link. It watches the five servo busy lines and the five IR drop sensors, and counts debounced pill drops per channel while that channel is busy. When a job completes, it queues a 4-byte status frame. It is the transmit-side counterpart to the host command receiver, and sits beside the servo units in the top level, driving its own status TX pin.

---
 rtl/dispense_status_tx.sv | 245 ++++++++++++++++++++++++
 tb/tb_dispense_status_tx.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/dispense_status_tx.sv
// Dispense status transmitter: counts debounced IR drops per servo channel
// and reports each completed job as a 4-byte UART 8N1 frame.
module dispense_status_tx #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200,
  parameter int DEBOUNCE = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] busy_servo,
  input  logic [4:0] input_ir,
  output logic       tx,
  output logic       tx_busy,
  output logic       frame_done,
  output logic       lost_event
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD;
  localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [BW-1:0] BAUD_ONE  = BW'(1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE - 1);
  localparam logic [DW-1:0] DEB_ONE   = DW'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_DATA  = 3'd3,
    S_STOP  = 3'd4
  } state_t;

  function automatic logic [7:0] frame_check(input logic [7:0] b0, input logic [7:0] b1,
                                             input logic [7:0] b2);
    return b0 ^ b1 ^ b2;
  endfunction

  logic [4:0]          ir_meta_q, ir_sync_q;
  logic [4:0]          deb_q, deb_d;
  logic [4:0][DW-1:0]  deb_cnt_q, deb_cnt_d;
  logic [4:0]          busy_prev_q;
  logic [4:0][3:0]     drop_cnt_q, drop_cnt_d;
  logic [4:0][3:0]     snap_q, snap_d;
  logic [4:0]          pending_q, pending_d;
  state_t              state_q, state_d;
  logic [BW-1:0]       baud_cnt_q, baud_cnt_d;
  logic [2:0]          bit_idx_q, bit_idx_d;
  logic [1:0]          byte_idx_q, byte_idx_d;
  logic [3:0][7:0]     frame_q, frame_d;
  logic                tx_q, tx_d;
  logic                tx_busy_q, tx_busy_d;
  logic                frame_done_q, frame_done_d;
  logic                lost_event_q, lost_event_d;

  logic [4:0]          drop_s, rise_s, fall_s, clr_s;
  logic                load_s;
  logic [2:0]          sel_s;

  // Debounce, busy edge detection and per-channel drop counting
  always_comb begin
    deb_d      = deb_q;
    deb_cnt_d  = deb_cnt_q;
    drop_cnt_d = drop_cnt_q;
    drop_s     = 5'b00000;
    rise_s     = busy_servo & ~busy_prev_q;
    fall_s     = ~busy_servo & busy_prev_q;
    for (int i = 0; i < 5; i++) begin
      if (ir_sync_q[i] != deb_q[i]) begin
        if (deb_cnt_q[i] == DEB_LAST) begin
          deb_d[i]     = ir_sync_q[i];
          deb_cnt_d[i] = '0;
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + DEB_ONE;
        end
      end else begin
        deb_cnt_d[i] = '0;
      end
      drop_s[i] = deb_q[i] & ~deb_d[i];
      // The completion cycle still counts, so a drop edge there reaches the snapshot
      if (rise_s[i]) begin
        drop_cnt_d[i] = 4'd0;
      end else if (drop_s[i] && (busy_servo[i] || busy_prev_q[i]) && (drop_cnt_q[i] != 4'd15)) begin
        drop_cnt_d[i] = drop_cnt_q[i] + 4'd1;
      end else begin
        drop_cnt_d[i] = drop_cnt_q[i];
      end
    end
  end

  // Completion capture into pending/snapshot, racing against LOAD clearing
  always_comb begin
    clr_s        = load_s ? (5'b00001 << sel_s) : 5'b00000;
    pending_d    = pending_q & ~clr_s;
    snap_d       = snap_q;
    lost_event_d = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (fall_s[i]) begin
        snap_d[i]    = drop_cnt_d[i];
        pending_d[i] = 1'b1;
        if (pending_q[i] && !clr_s[i]) begin
          lost_event_d = 1'b1;
        end else begin
          lost_event_d = lost_event_d;
        end
      end else begin
        snap_d[i] = snap_q[i];
      end
    end
  end

  // Transmit FSM: next state, bit timing and registered serial level
  always_comb begin
    state_d      = state_q;
    baud_cnt_d   = baud_cnt_q;
    bit_idx_d    = bit_idx_q;
    byte_idx_d   = byte_idx_q;
    frame_d      = frame_q;
    tx_d         = tx_q;
    frame_done_d = 1'b0;
    load_s       = 1'b0;
    sel_s        = 3'd0;
    for (int i = 4; i >= 0; i--) begin
      if (pending_q[i]) begin
        sel_s = 3'(i);
      end else begin
        sel_s = sel_s;
      end
    end
    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (|pending_q) begin
          state_d = S_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        load_s     = 1'b1;
        frame_d[0] = 8'hA5;
        frame_d[1] = {5'b00000, sel_s};
        frame_d[2] = {4'h0, snap_q[sel_s]};
        frame_d[3] = frame_check(8'hA5, {5'b00000, sel_s}, {4'h0, snap_q[sel_s]});
        byte_idx_d = 2'd0;
        bit_idx_d  = 3'd0;
        baud_cnt_d = '0;
        tx_d       = 1'b0;
        state_d    = S_START;
      end
      S_START: begin
        if (baud_cnt_q == BAUD_LAST) begin
          baud_cnt_d = '0;
          bit_idx_d  = 3'd0;
          tx_d       = frame_q[byte_idx_q][0];
          state_d    = S_DATA;
        end else begin
          baud_cnt_d = baud_cnt_q + BAUD_ONE;
        end
      end
      S_DATA: begin
        if (baud_cnt_q == BAUD_LAST) begin
          baud_cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = frame_q[byte_idx_q][bit_idx_q + 3'd1];
          end
        end else begin
          baud_cnt_d = baud_cnt_q + BAUD_ONE;
        end
      end
      S_STOP: begin
        if (baud_cnt_q == BAUD_LAST) begin
          baud_cnt_d = '0;
          if (byte_idx_q != 2'd3) begin
            byte_idx_d = byte_idx_q + 2'd1;
            tx_d       = 1'b0;
            state_d    = S_START;
          end else begin
            tx_d         = 1'b1;
            frame_done_d = 1'b1;
            state_d      = S_IDLE;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + BAUD_ONE;
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = S_IDLE;
      end
    endcase
    tx_busy_d = (state_d != S_IDLE);
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      ir_meta_q    <= 5'b11111;
      ir_sync_q    <= 5'b11111;
      deb_q        <= 5'b11111;
      deb_cnt_q    <= '0;
      busy_prev_q  <= 5'b00000;
      drop_cnt_q   <= '0;
      snap_q       <= '0;
      pending_q    <= 5'b00000;
      state_q      <= S_IDLE;
      baud_cnt_q   <= '0;
      bit_idx_q    <= 3'd0;
      byte_idx_q   <= 2'd0;
      frame_q      <= '0;
      tx_q         <= 1'b1;
      tx_busy_q    <= 1'b0;
      frame_done_q <= 1'b0;
      lost_event_q <= 1'b0;
    end else begin
      ir_meta_q    <= input_ir;
      ir_sync_q    <= ir_meta_q;
      deb_q        <= deb_d;
      deb_cnt_q    <= deb_cnt_d;
      busy_prev_q  <= busy_servo;
      drop_cnt_q   <= drop_cnt_d;
      snap_q       <= snap_d;
      pending_q    <= pending_d;
      state_q      <= state_d;
      baud_cnt_q   <= baud_cnt_d;
      bit_idx_q    <= bit_idx_d;
      byte_idx_q   <= byte_idx_d;
      frame_q      <= frame_d;
      tx_q         <= tx_d;
      tx_busy_q    <= tx_busy_d;
      frame_done_q <= frame_done_d;
      lost_event_q <= lost_event_d;
    end
  end

  assign tx         = tx_q;
  assign tx_busy    = tx_busy_q;
  assign frame_done = frame_done_q;
  assign lost_event = lost_event_q;

endmodule

// File: tb/tb_dispense_status_tx.sv
// Bench for dispense_status_tx: stimulus pushes expected frames into a
// scoreboard; a UART monitor decodes tx and compares against it.
module tb_dispense_status_tx;

  localparam int BD = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] busy = 5'b00000;
  logic [4:0] ir = 5'b11111;
  logic       tx, tx_busy, frame_done, lost_event;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int lost_cnt = 0;
  logic [31:0] exp_q[$];
  bit abort_frame = 1'b0;

  dispense_status_tx #(.CLK_FREQ(1000), .BAUD(100), .DEBOUNCE(4)) dut (
    .clk(clk), .rst(rst), .busy_servo(busy), .input_ir(ir),
    .tx(tx), .tx_busy(tx_busy), .frame_done(frame_done), .lost_event(lost_event)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_done) done_cnt <= done_cnt + 1;
    if (lost_event) lost_cnt <= lost_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, want);
    end
  endtask

  function automatic logic [31:0] mk(input int ch, input int n);
    logic [7:0] b0, b1, b2, b3;
    b0 = 8'hA5;
    b1 = 8'(ch);
    b2 = (n > 15) ? 8'd15 : 8'(n);
    b3 = b0 ^ b1 ^ b2;
    return {b3, b2, b1, b0};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input int ch, input int len);
    ir[ch] = 1'b0;
    tick(len);
    ir[ch] = 1'b1;
    tick(8);
  endtask

  // One job: busy high, nd real drops, ng glitches, then busy falls.
  task automatic job(input int ch, input int nd, input int ng, input int hold, input bit push);
    int el;
    busy[ch] = 1'b1;
    tick(20);
    el = 20;
    for (int d = 0; d < nd; d++) begin pulse(ch, 10); el += 18; end
    for (int g = 0; g < ng; g++) begin pulse(ch, 3); el += 11; end
    if (hold - 20 > el) tick(hold - 20 - el);
    tick(20);
    busy[ch] = 1'b0;
    if (push) exp_q.push_back(mk(ch, nd));
  endtask

  task automatic wait_done(input string name);
    int t;
    t = 0;
    tick(1);
    while (!frame_done && t < 3000) begin tick(1); t++; end
    if (t >= 3000) check({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  // UART monitor: samples each bit at its centre and compares with scoreboard.
  initial begin : monitor
    logic [39:0] bits;
    logic [31:0] frm;
    bit ok;
    int off;
    forever begin
      @(negedge clk);
      if (!rst && tx === 1'b0) begin
        off = 0;
        for (int k = 0; k < 40; k++) begin
          repeat (10 * k + 5 - off) @(negedge clk);
          off = 10 * k + 5;
          bits[k] = tx;
        end
        repeat (400 - off) @(negedge clk);
        if (abort_frame) begin
          abort_frame = 1'b0;
        end else begin
          ok = 1'b1;
          for (int n = 0; n < 4; n++) begin
            if (bits[n*10] !== 1'b0 || bits[n*10+9] !== 1'b1) ok = 1'b0;
            for (int b = 0; b < 8; b++) frm[n*8+b] = bits[n*10+1+b];
          end
          check("framing", 32'(ok), 32'd1);
          if (exp_q.size() == 0) begin
            check("unexpected_frame", frm, 32'd0);
          end else begin
            check("frame", frm, exp_q.pop_front());
          end
          check("frame_done_at_400", 32'(frame_done), 32'd1);
        end
      end
    end
  end

  initial begin : stim
    int d0, l0, gap, lows, t;
    tick(3);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_tx_busy", 32'(tx_busy), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_lost_event", 32'(lost_event), 32'd0);
    rst = 1'b0;
    tick(5);

    // Single job, 3 drops, ~500 cycle busy window, plus start latency
    job(2, 3, 0, 500, 1'b1);
    d0 = done_cnt;
    tick(1);
    check("lat_idle_tx", 32'(tx), 32'd1);
    check("lat_idle_busy", 32'(tx_busy), 32'd0);
    tick(1);
    check("lat_load_tx", 32'(tx), 32'd1);
    check("lat_load_busy", 32'(tx_busy), 32'd1);
    tick(1);
    check("lat_start_tx", 32'(tx), 32'd0);
    wait_done("single");
    tick(2);
    check("single_done_pulses", 32'(done_cnt - d0), 32'd1);

    // Saturation
    job(0, 17, 0, 0, 1'b1);
    wait_done("sat");

    // Glitch rejection and idle drops
    pulse(4, 10);
    pulse(4, 10);
    job(4, 0, 3, 0, 1'b1);
    wait_done("glitch");

    // Simultaneous completions
    busy[1] = 1'b1; busy[3] = 1'b1;
    tick(30);
    busy[1] = 1'b0; busy[3] = 1'b0;
    exp_q.push_back(mk(1, 0));
    exp_q.push_back(mk(3, 0));
    wait_done("sim1");
    gap = 0; lows = tx_busy ? 0 : 1;
    while (tx !== 1'b0 && gap < 20) begin
      tick(1); gap++;
      if (!tx_busy) lows++;
    end
    check("sim_gap", 32'(gap), 32'd2);
    check("sim_busy_low_1to2", 32'(lows >= 1 && lows <= 2), 32'd1);
    wait_done("sim2");

    // Overwrite while channel 0 frame is in flight
    l0 = lost_cnt;
    job(0, 1, 0, 0, 1'b1);
    tick(5);
    busy[1] = 1'b1; tick(20); busy[1] = 1'b0;
    tick(10);
    job(1, 2, 0, 0, 1'b1);
    wait_done("ow0");
    wait_done("ow1");
    tick(2);
    check("overwrite_lost", 32'(lost_cnt - l0), 32'd1);

    // Randomized jobs
    for (int r = 0; r < 6; r++) begin
      int ch, nd, ng, ni;
      ch = $urandom_range(0, 4);
      nd = $urandom_range(0, 17);
      ng = $urandom_range(0, 2);
      ni = $urandom_range(0, 1);
      for (int i = 0; i < ni; i++) pulse(ch, 10);
      job(ch, nd, ng, 0, 1'b1);
      wait_done("rand");
    end
    tick(10);

    // Reset during DATA of byte 1
    job(3, 1, 0, 0, 1'b0);
    t = 0;
    while (tx !== 1'b0 && t < 50) begin tick(1); t++; end
    check("rst_test_start_seen", 32'(t < 50), 32'd1);
    tick(135);
    abort_frame = 1'b1;
    rst = 1'b1;
    tick(1);
    check("midrst_tx", 32'(tx), 32'd1);
    check("midrst_tx_busy", 32'(tx_busy), 32'd0);
    rst = 1'b0;
    lows = 0;
    for (int i = 0; i < 600; i++) begin
      tick(1);
      if (tx !== 1'b1) lows++;
    end
    check("no_frame_after_rst", 32'(lows), 32'd0);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
